// File: rtl/gpio_ctl_pkg.sv
// Shared definitions for the GPIO controller: register offsets, AXI response
// codes, FSM state encodings and the byte-strobe expansion helper.
package gpio_ctl_pkg;

    localparam logic [2:0] REG_ODATA      = 3'd0;
    localparam logic [2:0] REG_OENABLE    = 3'd1;
    localparam logic [2:0] REG_IDATA      = 3'd2;
    localparam logic [2:0] REG_IRQ_EN     = 3'd3;
    localparam logic [2:0] REG_IRQ_EDGE   = 3'd4;
    localparam logic [2:0] REG_IRQ_STATUS = 3'd5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [3:0] {
        W_IDLE   = 4'b0001,
        W_HAVE_A = 4'b0010,
        W_HAVE_D = 4'b0100,
        W_RESP   = 4'b1000
    } wstate_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'b01,
        R_RESP = 2'b10
    } rstate_e;

    // Expand a 4-bit byte strobe into a 32-bit bit mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) begin
            m[8*k +: 8] = {8{strb[k]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_ctl_if.sv
// AXI4-Lite control port of the GPIO controller.
interface gpio_ctl_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/gpio_sync.sv
// Input pin synchroniser followed by a one-flop history stage for edge detection.
module gpio_sync #(
    parameter int N           = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] idata,
    output logic [N-1:0] isync,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
);
    logic [N-1:0] sync_q [SYNC_STAGES];
    logic [N-1:0] sync_d [SYNC_STAGES];
    logic [N-1:0] iprev_q;
    logic [N-1:0] iprev_d;

    // Shift the raw pin sample down the chain; iprev holds last cycle's synchronised value.
    always_comb begin
        sync_d[0] = idata;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        iprev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and history flops, cleared on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            iprev_q <= '0;
        end else begin
            sync_q  <= sync_d;
            iprev_q <= iprev_d;
        end
    end

    assign isync = sync_q[SYNC_STAGES-1];
    assign rise  = isync & ~iprev_q;
    assign fall  = ~isync & iprev_q;
endmodule

// File: rtl/gpio_ctl.sv
// AXI4-Lite GPIO controller: N output/enable pins, synchronised inputs and
// per-pin edge interrupts behind independent write and read FSMs.
module gpio_ctl
    import gpio_ctl_pkg::*;
#(
    parameter int N           = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    gpio_ctl_if.slave    t_ctrl,
    output logic [N-1:0] odata,
    output logic [N-1:0] oenable,
    input  logic [N-1:0] idata,
    output logic         irq
);
    wstate_e      wstate_q;
    logic         awready_q, wready_q, bvalid_q;
    logic [1:0]   bresp_q;
    logic [2:0]   waddr_q;
    logic [N-1:0] wdata_q;
    logic [3:0]   wstrb_q;

    rstate_e      rstate_q;
    logic         arready_q, rvalid_q;
    logic [31:0]  rdata_q;
    logic [1:0]   rresp_q;

    logic [N-1:0] odata_q, odata_d, oenable_q, oenable_d;
    logic [N-1:0] irq_en_q, irq_en_d, irq_edge_q, irq_edge_d;
    logic [N-1:0] irq_status_q, irq_status_d;
    logic         irq_q, irq_d;

    logic [N-1:0] isync, rise, fall, edge_set;
    logic         aw_hs, w_hs, ar_hs, wr_fire;
    logic [2:0]   wr_off;
    logic [N-1:0] wr_data, wr_mask, w1c_mask;
    logic [3:0]   wr_strb;
    logic [1:0]   wr_resp;
    logic [31:0]  strb_bits;
    logic [31:0]  rd_data;
    logic [1:0]   rd_resp;
    logic         unused_bits;

    function automatic logic [N-1:0] merge(input logic [N-1:0] old_v,
                                           input logic [N-1:0] new_v,
                                           input logic [N-1:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    gpio_sync #(.N(N), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .idata   (idata),
        .isync   (isync),
        .rise    (rise),
        .fall    (fall)
    );

    assign aw_hs = t_ctrl.awvalid & awready_q;
    assign w_hs  = t_ctrl.wvalid & wready_q;
    assign ar_hs = t_ctrl.arvalid & arready_q;

    // Decide whether the write completes this cycle; address/data come live from the bus when handshaking now.
    always_comb begin
        case (wstate_q)
            W_IDLE:   wr_fire = aw_hs & w_hs;
            W_HAVE_A: wr_fire = w_hs;
            W_HAVE_D: wr_fire = aw_hs;
            default:  wr_fire = 1'b0;
        endcase
        wr_off    = aw_hs ? t_ctrl.awaddr[4:2] : waddr_q;
        wr_data   = w_hs ? t_ctrl.wdata[N-1:0] : wdata_q;
        wr_strb   = w_hs ? t_ctrl.wstrb : wstrb_q;
        strb_bits = strb_mask(wr_strb);
        wr_mask   = strb_bits[N-1:0];
        wr_resp   = (wr_off > REG_IRQ_STATUS) ? RESP_SLVERR : RESP_OKAY;
    end

    // Register file next state; an edge event overrides a simultaneous W1C clear.
    always_comb begin
        odata_d    = odata_q;
        oenable_d  = oenable_q;
        irq_en_d   = irq_en_q;
        irq_edge_d = irq_edge_q;
        w1c_mask   = '0;
        if (wr_fire) begin
            case (wr_off)
                REG_ODATA:      odata_d    = merge(odata_q, wr_data, wr_mask);
                REG_OENABLE:    oenable_d  = merge(oenable_q, wr_data, wr_mask);
                REG_IRQ_EN:     irq_en_d   = merge(irq_en_q, wr_data, wr_mask);
                REG_IRQ_EDGE:   irq_edge_d = merge(irq_edge_q, wr_data, wr_mask);
                REG_IRQ_STATUS: w1c_mask   = wr_data & wr_mask;
                default:        ;
            endcase
        end
        edge_set     = (irq_edge_q & rise) | (~irq_edge_q & fall);
        irq_status_d = (irq_status_q & ~w1c_mask) | edge_set;
        irq_d        = |(irq_status_q & irq_en_q);
    end

    // Register file and interrupt output flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            odata_q      <= '0;
            oenable_q    <= '0;
            irq_en_q     <= '0;
            irq_edge_q   <= '0;
            irq_status_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            odata_q      <= odata_d;
            oenable_q    <= oenable_d;
            irq_en_q     <= irq_en_d;
            irq_edge_q   <= irq_edge_d;
            irq_status_q <= irq_status_d;
            irq_q        <= irq_d;
        end
    end

    // Write FSM: latch AW and W independently, respond once both have arrived.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            if (aw_hs) waddr_q <= t_ctrl.awaddr[4:2];
            if (w_hs) begin
                wdata_q <= t_ctrl.wdata[N-1:0];
                wstrb_q <= t_ctrl.wstrb;
            end
            if (wr_fire) begin
                wstate_q  <= W_RESP;
                awready_q <= 1'b0;
                wready_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= wr_resp;
            end else begin
                case (wstate_q)
                    W_IDLE: begin
                        if (aw_hs) begin
                            wstate_q  <= W_HAVE_A;
                            awready_q <= 1'b0;
                        end else if (w_hs) begin
                            wstate_q <= W_HAVE_D;
                            wready_q <= 1'b0;
                        end
                    end
                    W_HAVE_A, W_HAVE_D: ;
                    W_RESP: begin
                        if (t_ctrl.bready) begin
                            wstate_q  <= W_IDLE;
                            awready_q <= 1'b1;
                            wready_q  <= 1'b1;
                            bvalid_q  <= 1'b0;
                        end
                    end
                    default: begin
                        wstate_q  <= W_IDLE;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        bvalid_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Read data mux on the live AR address; unmapped offsets read zero with SLVERR.
    always_comb begin
        rd_resp = RESP_OKAY;
        case (t_ctrl.araddr[4:2])
            REG_ODATA:      rd_data = 32'(odata_q);
            REG_OENABLE:    rd_data = 32'(oenable_q);
            REG_IDATA:      rd_data = 32'(isync);
            REG_IRQ_EN:     rd_data = 32'(irq_en_q);
            REG_IRQ_EDGE:   rd_data = 32'(irq_edge_q);
            REG_IRQ_STATUS: rd_data = 32'(irq_status_q);
            default: begin
                rd_data = '0;
                rd_resp = RESP_SLVERR;
            end
        endcase
    end

    // Read FSM: capture data on the AR handshake and hold it until accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        rstate_q  <= R_RESP;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rd_data;
                        rresp_q   <= rd_resp;
                    end
                end
                R_RESP: begin
                    if (t_ctrl.rready) begin
                        rstate_q  <= R_IDLE;
                        arready_q <= 1'b1;
                        rvalid_q  <= 1'b0;
                    end
                end
                default: begin
                    rstate_q  <= R_IDLE;
                    arready_q <= 1'b1;
                    rvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign t_ctrl.awready = awready_q;
    assign t_ctrl.wready  = wready_q;
    assign t_ctrl.bvalid  = bvalid_q;
    assign t_ctrl.bresp   = bresp_q;
    assign t_ctrl.arready = arready_q;
    assign t_ctrl.rvalid  = rvalid_q;
    assign t_ctrl.rdata   = rdata_q;
    assign t_ctrl.rresp   = rresp_q;
    assign odata          = odata_q;
    assign oenable        = oenable_q;
    assign irq            = irq_q;

    // Address bits outside [4:2], prot fields and data bits above N carry no meaning here.
    assign unused_bits = ^{t_ctrl.awaddr, t_ctrl.araddr, t_ctrl.awprot, t_ctrl.arprot,
                           t_ctrl.wdata, strb_bits};
endmodule

// File: tb/tb_gpio_ctl.sv
// Randomised scoreboard bench for gpio_ctl with directed corner cases.
module tb_gpio_ctl;
    localparam int N = 6;
    localparam int S = 2;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    gpio_ctl_if bus ();
    gpio_ctl_if bus32 ();

    logic [N-1:0] odata, oenable, idata;
    logic         irq;
    logic [31:0]  odata32, oen32, idata32;
    logic         irq32;

    gpio_ctl #(.N(N), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset_n(reset_n), .t_ctrl(bus),
        .odata(odata), .oenable(oenable), .idata(idata), .irq(irq)
    );

    gpio_ctl #(.N(32), .SYNC_STAGES(3)) dut32 (
        .clk(clk), .reset_n(reset_n), .t_ctrl(bus32),
        .odata(odata32), .oenable(oen32), .idata(idata32), .irq(irq32)
    );

    // Reference model state
    logic [N-1:0] m_odata, m_oen, m_ien, m_iedge, m_status, m_idata;
    exp_t bq[$];
    exp_t rq[$];

    int n_cmp = 0, n_err = 0;
    int mon_cmp = 0, mon_err = 0;
    int b_done = 0, r_done = 0;
    int bready_mode = 1, rready_mode = 1;   // 0 low, 1 random, 2 high

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] bmask(input logic [3:0] s);
        logic [31:0] m = 0;
        for (int k = 0; k < 4; k++) if (s[k]) m = m | (32'hFF << (8 * k));
        return m[N-1:0];
    endfunction

    function automatic exp_t model_write(input logic [2:0] off, input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        logic [N-1:0] m, v;
        m = bmask(s);
        v = d[N-1:0];
        e.resp = 2'b00;
        e.data = 0;
        case (off)
            3'd0: m_odata = (m_odata & ~m) | (v & m);
            3'd1: m_oen   = (m_oen & ~m) | (v & m);
            3'd3: m_ien   = (m_ien & ~m) | (v & m);
            3'd4: m_iedge = (m_iedge & ~m) | (v & m);
            3'd5: m_status = m_status & ~(v & m);
            3'd6, 3'd7: e.resp = 2'b10;
            default: ;
        endcase
        return e;
    endfunction

    function automatic exp_t model_read(input logic [2:0] off);
        exp_t e;
        e.resp = 2'b00;
        case (off)
            3'd0: e.data = 32'(m_odata);
            3'd1: e.data = 32'(m_oen);
            3'd2: e.data = 32'(m_idata);
            3'd3: e.data = 32'(m_ien);
            3'd4: e.data = 32'(m_iedge);
            3'd5: e.data = 32'(m_status);
            default: begin e.data = 0; e.resp = 2'b10; end
        endcase
        return e;
    endfunction

    // Pin change: a bit latches when it moved in the direction its edge bit selects.
    function automatic void model_pins(input logic [N-1:0] nv);
        logic [N-1:0] up, dn;
        up = nv & ~m_idata;
        dn = ~nv & m_idata;
        m_status = m_status | (m_iedge & up) | (~m_iedge & dn);
        m_idata = nv;
    endfunction

    // Ready generators
    initial forever begin
        @(posedge clk);
        #1;
        bus.bready = (bready_mode == 2) || (bready_mode == 1 && $urandom_range(0, 3) != 0);
        bus.rready = (rready_mode == 2) || (rready_mode == 1 && $urandom_range(0, 3) != 0);
    end

    // Response monitor: pops the scoreboard on every B/R handshake
    initial begin
        exp_t e;
        logic        hold = 1'b0;
        logic [31:0] hold_data = 0;
        logic [1:0]  hold_resp = 0;
        forever begin
            @(negedge clk);
            if (bus.rvalid && hold) begin
                mon_cmp++;
                if (bus.rdata !== hold_data || bus.rresp !== hold_resp) begin
                    mon_err++;
                    $display("FAIL r_hold: got %h/%b, expected %h/%b", bus.rdata, bus.rresp, hold_data, hold_resp);
                end
            end
            hold = bus.rvalid && !bus.rready;
            hold_data = bus.rdata;
            hold_resp = bus.rresp;
            if (bus.bvalid && bus.bready) begin
                mon_cmp++;
                if (bq.size() == 0) begin
                    mon_err++;
                    $display("FAIL b_unexpected: got resp %b, expected no response", bus.bresp);
                end else begin
                    e = bq.pop_front();
                    if (bus.bresp !== e.resp) begin
                        mon_err++;
                        $display("FAIL bresp: got %b, expected %b", bus.bresp, e.resp);
                    end
                end
                b_done++;
            end
            if (bus.rvalid && bus.rready) begin
                mon_cmp++;
                if (rq.size() == 0) begin
                    mon_err++;
                    $display("FAIL r_unexpected: got %h, expected no response", bus.rdata);
                end else begin
                    e = rq.pop_front();
                    if (bus.rdata !== e.data || bus.rresp !== e.resp) begin
                        mon_err++;
                        $display("FAIL rdata: got %h/%b, expected %h/%b", bus.rdata, bus.rresp, e.data, e.resp);
                    end
                end
                r_done++;
            end
        end
    end

    task automatic drive_aw(input logic [31:0] a, input int dly, output bit ok);
        bit hs;
        ok = 0;
        @(posedge clk);
        repeat (dly) @(posedge clk);
        #1;
        bus.awvalid = 1'b1; bus.awaddr = a; bus.awprot = 3'($urandom);
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); hs = bus.awready;
            @(posedge clk); if (hs) ok = 1;
        end
        #1 bus.awvalid = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly, output bit ok);
        bit hs;
        ok = 0;
        @(posedge clk);
        repeat (dly) @(posedge clk);
        #1;
        bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = s;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); hs = bus.wready;
            @(posedge clk); if (hs) ok = 1;
        end
        #1 bus.wvalid = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int awd, input int wd);
        bit ok_a, ok_w;
        int start;
        bq.push_back(model_write(a[4:2], d, s));
        start = b_done;
        fork
            drive_aw(a, awd, ok_a);
            drive_w(d, s, wd, ok_w);
        join
        check("aw_handshake", 32'(ok_a), 1);
        check("w_handshake", 32'(ok_w), 1);
        for (int i = 0; i < 200 && b_done == start; i++) @(posedge clk);
        check("b_timeout", 32'(b_done > start), 1);
    endtask

    task automatic axi_read(input logic [31:0] a, input int dly);
        bit ok, hs;
        int start;
        rq.push_back(model_read(a[4:2]));
        start = r_done;
        ok = 0;
        @(posedge clk);
        repeat (dly) @(posedge clk);
        #1;
        bus.arvalid = 1'b1; bus.araddr = a; bus.arprot = 3'($urandom);
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); hs = bus.arready;
            @(posedge clk); if (hs) ok = 1;
        end
        #1 bus.arvalid = 1'b0;
        check("ar_handshake", 32'(ok), 1);
        for (int i = 0; i < 200 && r_done == start; i++) @(posedge clk);
        check("r_timeout", 32'(r_done > start), 1);
    endtask

    task automatic check_pins();
        @(negedge clk);
        check("odata", 32'(odata), 32'(m_odata));
        check("oenable", 32'(oenable), 32'(m_oen));
        check("irq", 32'(irq), 32'(|(m_status & m_ien)));
    endtask

    task automatic set_pins(input logic [N-1:0] nv);
        @(posedge clk);
        #1 idata = nv;
        repeat (S + 3) @(posedge clk);
        model_pins(nv);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r32, a, d;
        logic [N-1:0] nv;
        int op;
        bus.awvalid = 0; bus.awaddr = 0; bus.awprot = 0; bus.wvalid = 0; bus.wdata = 0;
        bus.wstrb = 0; bus.bready = 0; bus.arvalid = 0; bus.araddr = 0; bus.arprot = 0;
        bus.rready = 0;
        bus32.awvalid = 0; bus32.awaddr = 0; bus32.awprot = 0; bus32.wvalid = 0;
        bus32.wdata = 0; bus32.wstrb = 0; bus32.bready = 1; bus32.arvalid = 0;
        bus32.araddr = 0; bus32.arprot = 0; bus32.rready = 1;
        idata = 0; idata32 = 0;
        m_odata = 0; m_oen = 0; m_ien = 0; m_iedge = 0; m_status = 0; m_idata = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_odata", 32'(odata), 0);
        check("rst_oenable", 32'(oenable), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_bvalid", 32'(bus.bvalid), 0);
        check("rst_rvalid", 32'(bus.rvalid), 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_resps", 32'({bus.bresp, bus.rresp}), 0);
        check("rst_readies", 32'({bus.awready, bus.wready, bus.arready}), 3'b111);

        // 32-pin instance: only byte 2 written
        @(posedge clk);
        #1 bus32.awvalid = 1; bus32.awaddr = 32'h0; bus32.wvalid = 1;
        bus32.wdata = 32'hFFFF_FFFF; bus32.wstrb = 4'b0100;
        @(posedge clk);
        #1 bus32.awvalid = 0; bus32.wvalid = 0;
        @(negedge clk);
        check("n32_bvalid", 32'(bus32.bvalid), 1);
        check("n32_bresp", 32'(bus32.bresp), 0);
        check("n32_odata", odata32, 32'h00FF_0000);

        // AW and W together: bvalid one cycle after the handshake
        bready_mode = 0;
        @(posedge clk); #1;
        fork
            axi_write(32'h0, 32'h2A, 4'b0001, 0, 0);
            begin
                @(posedge clk); @(negedge clk);
                check("w1_bvalid_early", 32'(bus.bvalid), 0);
                @(posedge clk); @(negedge clk);
                check("w1_bvalid", 32'(bus.bvalid), 1);
                check("w1_odata", 32'(odata), 32'h2A);
                bready_mode = 2;
            end
        join
        axi_read(32'h0, 0);
        check_pins();

        // W first, AW three cycles later
        bready_mode = 0;
        @(posedge clk); #1;
        fork
            axi_write(32'h4, 32'h3F, 4'b0001, 3, 0);
            begin
                @(posedge clk); @(posedge clk); @(negedge clk);
                check("hd_awready", 32'(bus.awready), 1);
                check("hd_wready", 32'(bus.wready), 0);
                check("hd_oenable", 32'(oenable), 0);
                @(posedge clk); @(posedge clk); @(negedge clk);
                check("hd_oenable_pre", 32'(oenable), 0);
                @(posedge clk); @(negedge clk);
                check("hd_oenable_post", 32'(oenable), 32'h3F);
                bready_mode = 2;
            end
        join
        axi_write(32'h4, 32'h0, 4'b0000, 0, 0);
        check_pins();

        // Unmapped offset with a stalled B channel
        bready_mode = 0;
        fork
            axi_write(32'h18, 32'hFFFF_FFFF, 4'b1111, 0, 0);
            begin
                for (int i = 0; i < 50 && !bus.bvalid; i++) @(negedge clk);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("stall_bvalid", 32'(bus.bvalid), 1);
                    check("stall_awready", 32'(bus.awready), 0);
                end
                bready_mode = 2;
            end
        join
        axi_read(32'h18, 1);
        check_pins();

        // Rising-edge interrupt on pin 0 with exact latency
        axi_write(32'h14, 32'h3F, 4'b0001, 0, 0);
        axi_write(32'h10, 32'h01, 4'b0001, 0, 0);
        axi_write(32'h0C, 32'h01, 4'b0001, 1, 0);
        check_pins();
        nv = m_idata | 1;
        @(posedge clk);
        #1 idata = nv;
        for (int k = 1; k <= S + 2; k++) begin
            @(posedge clk); @(negedge clk);
            check("irq_latency", 32'(irq), 32'(k >= S + 2));
        end
        model_pins(nv);
        axi_read(32'h14, 0);
        set_pins(m_idata & ~1);
        axi_read(32'h14, 0);
        check_pins();
        axi_write(32'h14, 32'h1, 4'b0001, 0, 0);
        check_pins();
        axi_read(32'h14, 0);

        // W1C of status[2] coinciding with a new rise on pin 2
        axi_write(32'h10, 32'h05, 4'b0001, 0, 0);
        set_pins(m_idata | 6'h04);
        set_pins(m_idata & ~6'h04);
        axi_read(32'h14, 0);
        nv = m_idata | 6'h04;
        @(posedge clk); #1;
        fork
            idata = nv;
            axi_write(32'h14, 32'h04, 4'b0001, S - 1, S - 1);
        join
        model_pins(nv);
        axi_read(32'h14, 0);
        check_pins();

        // Randomised traffic
        bready_mode = 1;
        rready_mode = 1;
        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 9);
            a = $urandom;
            a[4:2] = 3'($urandom_range(0, 7));
            if (op < 4) begin
                d = $urandom;
                axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
            end else if (op < 8) begin
                axi_read(a, $urandom_range(0, 2));
            end else begin
                r32 = $urandom;
                set_pins(r32[N-1:0]);
            end
            check_pins();
        end

        // Reset in the middle of a write (AW accepted, W pending)
        bready_mode = 2;
        rready_mode = 2;
        axi_write(32'h0, 32'h15, 4'b0001, 0, 0);
        axi_write(32'h4, 32'h2A, 4'b0001, 0, 0);
        axi_write(32'h10, 32'h3F, 4'b0001, 0, 0);
        axi_write(32'h0C, 32'h3F, 4'b0001, 0, 0);
        set_pins(~m_idata);
        check_pins();
        @(posedge clk);
        #1 bus.awvalid = 1; bus.awaddr = 32'h0;
        @(posedge clk);
        #1 bus.awvalid = 0;
        @(negedge clk);
        check("mid_awready", 32'(bus.awready), 0);
        #2 reset_n = 1'b0; idata = 0;
        #1;
        check("mrst_odata", 32'(odata), 0);
        check("mrst_oenable", 32'(oenable), 0);
        check("mrst_irq", 32'(irq), 0);
        check("mrst_valids", 32'({bus.bvalid, bus.rvalid}), 0);
        check("mrst_readies", 32'({bus.awready, bus.wready, bus.arready}), 3'b111);
        @(posedge clk);
        #1 reset_n = 1'b1;
        m_odata = 0; m_oen = 0; m_ien = 0; m_iedge = 0; m_status = 0; m_idata = 0;
        axi_write(32'h0, 32'h03, 4'b0001, 0, 0);
        axi_read(32'h0, 0);
        axi_read(32'h4, 0);
        check_pins();

        repeat (3) @(posedge clk);
        check("bq_empty", 32'(bq.size()), 0);
        check("rq_empty", 32'(rq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + mon_cmp, n_err + mon_err);
        $finish;
    end
endmodule

// File: doc/gpio_ctl.md
Name: gpio_ctl

Overview:
Parametrised AXI4-Lite GPIO controller; the next generation of the team's fixed 6-bit pin-control block.
- Drives N output data/enable pins and samples N input pins through a synchroniser.
- Raises a level interrupt on per-pin programmable edges.
- Honours byte strobes and returns SLVERR on unmapped addresses.
- Sits on the peripheral AXI4-Lite crossbar; pins route to pad ring, irq to the interrupt controller.

Parameters:
N, 6, pin count, legal 1..32
SYNC_STAGES, 2, idata synchroniser flops, legal 2..4

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
t_ctrl_awvalid/awready  in/out  1  AW handshake
t_ctrl_awaddr  in  32  write address; only [4:2] decoded
t_ctrl_awprot  in  3  ignored
t_ctrl_wvalid/wready  in/out  1  W handshake
t_ctrl_wdata  in  32  write data
t_ctrl_wstrb  in  4  byte enables
t_ctrl_bvalid/bready  out/in  1  B handshake
t_ctrl_bresp  out  2  OKAY(00) or SLVERR(10)
t_ctrl_arvalid/arready  in/out  1  AR handshake
t_ctrl_araddr  in  32  read address; [4:2] decoded
t_ctrl_arprot  in  3  ignored
t_ctrl_rvalid/rready  out/in  1  R handshake
t_ctrl_rdata  out  32  read data, bits above N zero
t_ctrl_rresp  out  2  OKAY or SLVERR
odata  out  N  output pin values
oenable  out  N  output drivers enable, 1=drive
idata  in  N  asynchronous input pins
irq  out  1  level interrupt

Behaviour:
- Register map, word offsets (addr[4:2]):
  - 0 ODATA rw
  - 1 OENABLE rw
  - 2 IDATA ro (synchronised value)
  - 3 IRQ_EN rw
  - 4 IRQ_EDGE rw (1=rising, 0=falling)
  - 5 IRQ_STATUS r/w1c
  - 6,7 unmapped
  - addr bits [1:0] and [31:5] ignored.
- Reset values: all registers 0; odata=0, oenable=0, irq=0; all valid outputs 0, bresp/rresp=00, rdata=0.
- Write FSM, one-hot states:
  - W_IDLE: awready=wready=1.
  - W_HAVE_A: awready=0, wready=1.
  - W_HAVE_D: awready=1, wready=0.
  - W_RESP: bvalid=1, both readies 0.
  - Transitions:
    - IDLE + AW&W same cycle -> RESP.
    - IDLE + AW only -> HAVE_A.
    - IDLE + W only -> HAVE_D.
    - HAVE_A + W -> RESP.
    - HAVE_D + AW -> RESP.
    - RESP + bready -> IDLE.
  - Address and data/strobe are latched on their handshakes. The register update happens in the cycle the FSM enters RESP. bvalid rises the next cycle; minimum write latency is 1.
  - At most one outstanding write.
- Byte strobes: byte k of a register is updated only if wstrb[k]. Bits >= N are not stored. wstrb=0 is an OKAY no-op.
- Writes to IDATA or unmapped offsets: no state change, bresp=SLVERR for unmapped, OKAY for IDATA (read-only write ignored).
- Read FSM:
  - R_IDLE: arready=1.
  - On the AR handshake: rdata/rresp are registered from the decoded offset, then -> R_RESP (rvalid=1, arready=0).
  - R_RESP + rready -> IDLE.
  - Read data latency 1. Data is held stable while rvalid && !rready.
- Unmapped read: rdata=0, rresp=SLVERR.
- Read and write FSMs are independent. A read concurrent with a write to the same register returns the pre-write value if the AR handshake precedes or coincides with the update cycle.
- Input path:
  - idata passes through SYNC_STAGES flops, reset 0, giving isync.
  - A one more flop gives iprev.
  - rise = isync & ~iprev; fall = ~isync & iprev.
- Interrupt status: per bit, set = IRQ_EDGE ? rise : fall.
  - IRQ_STATUS next = (status & ~w1c_mask) | set.
  - Set wins over a simultaneous W1C clear.
  - Status bits latch regardless of IRQ_EN.
- irq is registered: irq <= |(IRQ_STATUS & IRQ_EN), with one cycle of latency after the status/enable change.
- Changing IRQ_EDGE does not itself set status.
- Reset mid-transaction: both FSMs return to IDLE and pending transactions are dropped. The master must also be reset.

Decomposition:
- Package gpio_ctl_pkg holds:
  - register offset localparams (REG_ODATA=3'd0 … REG_IRQ_STATUS=3'd5)
  - RESP_OKAY/RESP_SLVERR
  - write/read FSM state encodings.
- One sub-module, gpio_sync: an N-wide SYNC_STAGES synchroniser plus edge detector, with outputs isync, rise, fall.

Test Plan:
- N=6: AW@0x0 and W=0x2A, wstrb=1 in the same cycle -> bvalid after 1 cycle, bresp=00, odata=6'h2A; read 0x0 returns 0x0000002A, rresp=00.
- W first (0x3F to OENABLE), then AW 3 cycles later -> awready=1 while in HAVE_D, oenable=6'h3F only after AW; wstrb=0 write -> oenable unchanged, OKAY.
- Write/read at 0x18 -> bresp=10, rresp=10, rdata=0, no register change; bready held low 5 cycles -> bvalid stays 1, awready=0.
- N=32: write 0xFFFFFFFF with wstrb=4'b0100 to ODATA -> odata=0x00FF0000.
- IRQ_EN=1, IRQ_EDGE=1, idata[0] 0->1 -> status[0]=1 after SYNC_STAGES+1 clocks, irq=1 one clock later; a falling edge does not set it; W1C 0x1 clears status and irq.
- W1C of status[2] in the same cycle as a new rise on pin 2 -> status[2] stays 1; assert reset_n mid-write -> all outputs 0 immediately, FSMs IDLE.
